// File: rtl/filtro_pkg.sv
// Shared definitions for the FILTRO time-multiplexed FIR engine:
// control states and width helpers used by the top and the MAC datapath.
package filtro_pkg;

    // state    | meaning
    // ST_IDLE  | waiting for a sample, coefficient writes allowed
    // ST_MAC   | one tap per cycle, cant_taps cycles
    // ST_OUT   | result presented, waiting for out_ready
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // Ceiling log2, never below 1 so a tap index always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // Accumulator width: full product plus growth for cant_taps additions.
    function automatic int acc_w(input int bits, input int taps);
        return 2 * bits - 1 + clog2(taps);
    endfunction

endpackage

// File: rtl/filtro_mac_dp.sv
// Registered signed multiply-accumulate: acc <= clr ? 0 : acc + a*b when enabled.
// The next-state value is exported so the caller can capture the final sum
// on the same edge that completes the last tap.
module filtro_mac_dp
    import filtro_pkg::*;
#(
    parameter int W     = 25,
    parameter int ACC_W = 52
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [W-1:0]     a_i,
    input  logic signed [W-1:0]     b_i,
    output logic signed [ACC_W-1:0] acc_d_o
);

    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    // Next accumulator value: clear has priority over accumulate.
    always_comb begin
        prod  = a_i * b_i;
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_d_o = acc_d;

endmodule

// File: rtl/filtro_fir_mac.sv
// Time-multiplexed FIR engine: one MAC reused for all taps over a circular
// sample history, followed by rescale, saturation and a valid/ready output.
module filtro_fir_mac
    import filtro_pkg::*;
#(
    parameter int cant_bits = 25,
    parameter int cant_taps = 8,
    parameter int frac_bits = 12,
    localparam int AW = clog2(cant_taps)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic signed [cant_bits-1:0] in_data_i,
    input  logic                        coef_we_i,
    input  logic [AW-1:0]               coef_addr_i,
    input  logic signed [cant_bits-1:0] coef_data_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic signed [cant_bits-1:0] out_data_o,
    output logic                        sat_o
);

    localparam int ACC_W = acc_w(cant_bits, cant_taps);

    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-cant_bits+1){1'b0}}, {(cant_bits-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-cant_bits+1){1'b1}}, {(cant_bits-1){1'b0}}};

    state_t                      state_q;
    logic [AW-1:0]               k_q;
    logic [AW-1:0]               wr_ptr_q;
    logic                        in_ready_q;
    logic                        out_valid_q;
    logic signed [cant_bits-1:0] out_data_q;
    logic                        sat_q;

    logic signed [cant_bits-1:0] hist_q [cant_taps];
    logic signed [cant_bits-1:0] coef_q [cant_taps];

    logic [AW-1:0]               rd_idx;
    logic                        last_tap;
    logic                        accept;
    logic signed [ACC_W-1:0]     acc_d;
    logic signed [ACC_W-1:0]     shifted;
    logic signed [cant_bits-1:0] y_sat;
    logic                        y_clip;

    assign accept   = (state_q == ST_IDLE) && in_valid_i;
    assign last_tap = (k_q == AW'(cant_taps - 1));

    // History read index (wr_ptr - k) mod cant_taps, valid for any tap count.
    always_comb begin
        if (k_q <= wr_ptr_q) begin
            rd_idx = wr_ptr_q - k_q;
        end else begin
            rd_idx = AW'(int'(wr_ptr_q) + cant_taps - int'(k_q));
        end
    end

    filtro_mac_dp #(
        .W     (cant_bits),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (accept),
        .en_i    (state_q == ST_MAC),
        .a_i     (coef_q[k_q]),
        .b_i     (hist_q[rd_idx]),
        .acc_d_o (acc_d)
    );

    // Rescale the final sum and clip it into the output word range.
    always_comb begin
        shifted = acc_d >>> frac_bits;
        if (shifted > OUT_MAX) begin
            y_sat  = OUT_MAX[cant_bits-1:0];
            y_clip = 1'b1;
        end else if (shifted < OUT_MIN) begin
            y_sat  = OUT_MIN[cant_bits-1:0];
            y_clip = 1'b1;
        end else begin
            y_sat  = shifted[cant_bits-1:0];
            y_clip = 1'b0;
        end
    end

    // History and coefficient storage; both only change while idle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < cant_taps; i++) begin
                hist_q[i] <= '0;
                coef_q[i] <= '0;
            end
        end else if (state_q == ST_IDLE) begin
            if (in_valid_i) begin
                hist_q[wr_ptr_q] <= in_data_i;
            end
            if (coef_we_i && (int'(coef_addr_i) < cant_taps)) begin
                coef_q[coef_addr_i] <= coef_data_i;
            end
        end
    end

    // Control FSM with registered handshake and output word.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            wr_ptr_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sat_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        state_q    <= ST_MAC;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                    end
                end
                ST_MAC: begin
                    if (last_tap) begin
                        state_q     <= ST_OUT;
                        wr_ptr_q    <= (wr_ptr_q == AW'(cant_taps - 1)) ? '0
                                                                      : wr_ptr_q + AW'(1);
                        out_valid_q <= 1'b1;
                        out_data_q  <= y_sat;
                        sat_q       <= y_clip;
                    end else begin
                        k_q <= k_q + AW'(1);
                    end
                end
                ST_OUT: begin
                    if (out_ready_i) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign sat_o       = sat_q;

endmodule

// File: tb/tb_filtro_fir_mac.sv
// Bench for filtro_fir_mac: a convolution model predicts each output when a
// sample is accepted; a monitor pops and compares on every output handshake.
module tb_filtro_fir_mac;

    localparam int CB = 25;
    localparam int CT = 8;
    localparam int FB = 12;
    localparam int AW = 3;

    typedef struct {
        longint data;
        bit     sat;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [CB-1:0] in_data = '0;
    logic                 coef_we = 1'b0;
    logic [AW-1:0]        coef_addr = '0;
    logic signed [CB-1:0] coef_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [CB-1:0] out_data;
    logic                 sat;

    int     n_checks = 0;
    int     n_errors = 0;
    int     cyc = 0;
    int     acc_cyc = 0;
    exp_t   sb_q[$];
    longint mh[CT];
    longint mx[CT];

    filtro_fir_mac #(
        .cant_bits (CB),
        .cant_taps (CT),
        .frac_bits (FB)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .coef_we_i   (coef_we),
        .coef_addr_i (coef_addr),
        .coef_data_i (coef_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .sat_o       (sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // y = sum h[k]*x[n-k], rescaled by >>> FB and clipped to CB bits.
    function automatic exp_t model_out();
        longint acc;
        longint hi;
        longint lo;
        exp_t   e;
        acc = 0;
        for (int k = 0; k < CT; k++) acc += mh[k] * mx[k];
        acc = acc >>> FB;
        hi = (longint'(1) <<< (CB - 1)) - 1;
        lo = -(longint'(1) <<< (CB - 1));
        if (acc > hi) begin
            e.data = hi; e.sat = 1'b1;
        end else if (acc < lo) begin
            e.data = lo; e.sat = 1'b1;
        end else begin
            e.data = acc; e.sat = 1'b0;
        end
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < CT; i++) begin
            mh[i] = 0;
            mx[i] = 0;
        end
    endtask

    // All tasks below start and end #1 after a rising edge.
    task automatic wait_idle();
        int guard;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) check_val("in_ready_timeout", 0, 1);
    endtask

    task automatic write_coef(input int k, input longint v);
        wait_idle();
        coef_we   = 1'b1;
        coef_addr = AW'(k);
        coef_data = v[CB-1:0];
        @(posedge clk); #1;
        coef_we = 1'b0;
        mh[k] = v;
    endtask

    task automatic send_sample(input longint x, input bit track);
        wait_idle();
        in_valid = 1'b1;
        in_data  = x[CB-1:0];
        acc_cyc  = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = CT - 1; i > 0; i--) mx[i] = mx[i-1];
        mx[0] = x;
        if (track) sb_q.push_back(model_out());
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((sb_q.size() != 0 || !in_ready) && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        if (sb_q.size() != 0) check_val("drain_timeout", sb_q.size(), 0);
    endtask

    // Output scoreboard: compare on every completed output handshake.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_output", out_data, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("out_data", out_data, e.data);
                check_val("sat", sat, e.sat);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ov_cyc;
        int guard;
        model_clear();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_sat", sat, 0);

        // Impulse response: y = 4096*(k+1) then 0
        for (int k = 0; k < CT; k++) write_coef(k, 4096 * (k + 1));
        send_sample(4096, 1);
        for (int i = 0; i < CT; i++) send_sample(0, 1);
        wait_drain();

        // Wrap-around: single unity tap passes samples through
        write_coef(0, 4096);
        for (int k = 1; k < CT; k++) write_coef(k, 0);
        for (int i = 0; i < 20; i++) begin
            longint x;
            x = longint'($urandom_range(0, 16777215)) - 8388608;
            send_sample(x, 1);
        end
        wait_drain();

        // Saturation, positive then negative
        for (int k = 0; k < CT; k++) write_coef(k, 16777215);
        for (int i = 0; i < CT; i++) send_sample(16777215, 1);
        for (int i = 0; i < CT; i++) send_sample(-16777216, 1);
        wait_drain();

        // Latency and backpressure
        for (int k = 0; k < CT; k++) write_coef(k, 4096 * (k + 1));
        out_ready = 1'b0;
        send_sample(12345, 1);
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        ov_cyc = cyc;
        check_val("latency", ov_cyc - acc_cyc, CT + 1);
        in_valid = 1'b1;
        in_data  = 999;
        for (int i = 0; i < 20; i++) begin
            check_val("bp_out_valid", out_valid, 1);
            check_val("bp_in_ready", in_ready, 0);
            if (sb_q.size() != 0) check_val("bp_out_data", out_data, sb_q[0].data);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        send_sample(-5000, 1);
        wait_drain();

        // Coefficient write during MAC must be ignored
        send_sample(4096, 1);
        coef_we   = 1'b1;
        coef_addr = '0;
        coef_data = 12345;
        @(posedge clk); #1;
        coef_we = 1'b0;
        send_sample(1000, 1);
        wait_drain();

        // Reset on the 4th MAC tap discards the computation
        send_sample(777, 0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        check_val("midrst_in_ready", in_ready, 1);
        check_val("midrst_out_valid", out_valid, 0);
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) check_val("midrst_stale_out", out_valid, 0);
        end
        for (int k = 0; k < CT; k++) write_coef(k, 4096 * (k + 1));
        send_sample(4096, 1);
        for (int i = 0; i < CT; i++) send_sample(0, 1);
        wait_drain();

        check_val("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
